mul_pipe: RTL
=============

MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter LATENCY, default 5, enabled cycles from acceptance to result; legal range 2..8.
REQ-003 SHALL have parameter TAG_WIDTH, default 5, destination-register tag width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  pipeline advance; low = stall/freeze.
REQ-007 SHALL have port flush  input  1  kill all in-flight operations.
REQ-008 SHALL have port in_valid  input  1  operation present on in_* this cycle.
REQ-009 SHALL have port in_op  input  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
REQ-010 SHALL have ports in_a, in_b  input  XLEN  operands (rs1, rs2).
REQ-011 SHALL have port in_tag  input  TAG_WIDTH  destination tag carried with the operation.
REQ-012 SHALL have port out_valid  output  1  result present on out_result/out_tag.
REQ-013 SHALL have port out_result  output  XLEN  selected product half.
REQ-014 SHALL have port out_tag  output  TAG_WIDTH  tag of the completing operation.
REQ-015 SHALL have port busy  output  1  OR of all stage valid bits, including output stage.

Function
REQ-016 SHALL contain LATENCY register stages; each holds valid, op, tag and data (operands or partial/final product).
REQ-017 SHALL accept an operation at a rising edge where in_valid=1, enable=1, flush=0; no ready signal, one acceptance per enabled cycle.
REQ-018 SHALL present an accepted operation with out_valid=1 exactly LATENCY enabled edges after acceptance; with enable held high, accepted at edge k -> visible after edge k+LATENCY-1... i.e. registered on edge k+LATENCY-1 when stage 1 is edge k.
REQ-019 SHALL, when enable=0 and flush=0, hold every stage register (valid, op, tag, data) unchanged; outputs stay stable.
REQ-020 SHALL preserve order: results leave in acceptance order, with bubbles preserved.
REQ-021 SHALL sign-extend in_a for MUL/MULH/MULHSU and zero-extend for MULHU; sign-extend in_b for MUL/MULH, zero-extend for MULHSU/MULHU; form a 2*XLEN+2 product.
REQ-022 SHALL output product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for MULH/MULHSU/MULHU.
REQ-023 SHALL split the multiply across stages so no single stage computes a full XLEN x XLEN product (e.g. partial-product accumulation), result bit-exact to REQ-021/022.
REQ-024 SHALL drive out_result and out_tag from the final stage registers, not combinationally from inputs.
REQ-025 SHALL, on flush=1 at a rising edge, clear every stage valid bit regardless of enable; data/tag registers may hold stale values.
REQ-026 SHALL drop an in_valid presented in the same cycle as flush=1.
REQ-027 SHALL treat out_valid as a one-cycle pulse per operation when enable=1; when enable=0 it stays asserted until the next enabled edge.
REQ-028 SHALL compute busy combinationally from stage valid bits; busy=0 only when the pipe is empty.

Reset
REQ-029 SHALL, on reset assertion, immediately clear all stage valid bits and set out_valid=0, out_result=0, out_tag=0, busy=0, without waiting for clk.
REQ-030 SHALL discard operations in flight when reset asserts mid-operation; none appear after reset deasserts.
REQ-031 SHALL give reset priority over flush and enable.

Verification
REQ-032 SHALL cover MUL: a=7, b=0xFFFFFFFD, tag=3, enable high -> after LATENCY edges out_valid=1, out_result=0xFFFFFFEB, out_tag=3, for exactly one cycle.
REQ-033 SHALL cover high halves: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 SHALL cover back-to-back: 5 ops on consecutive cycles, tags 1..5 -> 5 consecutive out_valid pulses, tags 1..5 in order, correct results.
REQ-035 SHALL cover stall: enable low for 3 cycles mid-flight -> outputs frozen, results arrive LATENCY+3 cycles after acceptance, none lost or duplicated.
REQ-036 SHALL cover flush: 3 ops in flight plus new in_valid with flush=1 -> no out_valid afterwards, busy=0 next cycle; op accepted the cycle after flush completes normally.
REQ-037 SHALL cover async reset mid-flight: reset asserted between clock edges -> out_valid, out_result, out_tag, busy read 0 before next edge; no stale result after deassertion.

Source files
------------

// File: rtl/mul_pipe.sv
// Pipelined RV32M-style multiplier (MUL/MULH/MULHSU/MULHU) with stall, flush and tag passthrough.
// The rs2 operand is consumed one chunk per stage so no stage forms a full-width product.
module mul_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned LATENCY   = 5,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [1:0]           in_op,
  input  logic [XLEN-1:0]      in_a,
  input  logic [XLEN-1:0]      in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_e;

  localparam int unsigned W  = 2 * XLEN + 2;
  localparam int unsigned CW = (XLEN + LATENCY - 1) / LATENCY;
  localparam int unsigned BP = LATENCY * CW;
  localparam int unsigned PW = XLEN + CW + 2;
  localparam int unsigned NM = LATENCY - 1;

  logic [LATENCY-1:0]   vld;
  op_e                  op_q  [NM];
  logic [TAG_WIDTH-1:0] tag_q [LATENCY];
  logic [XLEN:0]        a_q   [NM];
  logic [XLEN:0]        b_q   [NM];
  logic signed [W-1:0]  acc_q [NM];
  logic [XLEN-1:0]      res_q;

  op_e                  op_in;
  logic [XLEN:0]        a_in_ext;
  logic [XLEN:0]        b_in_ext;
  logic signed [W-1:0]  acc_n [NM];
  logic signed [W-1:0]  corr;
  logic signed [W-1:0]  full;
  logic [XLEN-1:0]      res_n;

  // Signed a times unsigned chunk idx of b's low XLEN bits, placed at its weight.
  function automatic logic signed [W-1:0] pp(input logic [XLEN:0] a,
                                              input logic [XLEN-1:0] b_low,
                                              input int unsigned idx);
    logic [BP-1:0]        bpad;
    logic [CW-1:0]        chunk;
    logic signed [PW-1:0] p;
    bpad  = BP'(b_low);
    chunk = bpad[idx*CW +: CW];
    p     = PW'($signed(a)) * PW'($signed({1'b0, chunk}));
    return W'(p) <<< (idx * CW);
  endfunction

  always_comb begin
    op_in    = op_e'(in_op);
    a_in_ext = {in_a[XLEN-1] & (op_in != OP_MULHU), in_a};
    b_in_ext = {in_b[XLEN-1] & ((op_in == OP_MUL) || (op_in == OP_MULH)), in_b};
    acc_n    = '{default: '0};
    acc_n[0] = pp(a_in_ext, b_in_ext[XLEN-1:0], 0);
    for (int unsigned i = 1; i < NM; i++) begin
      acc_n[i] = acc_q[i-1] + pp(a_q[i-1], b_q[i-1][XLEN-1:0], i);
    end
    // b's sign bit carries weight -2^XLEN, so subtract a shifted into place.
    corr  = b_q[NM-1][XLEN] ? (W'($signed(a_q[NM-1])) <<< XLEN) : '0;
    full  = acc_q[NM-1] + pp(a_q[NM-1], b_q[NM-1][XLEN-1:0], NM) - corr;
    res_n = (op_q[NM-1] == OP_MUL) ? XLEN'(full) : XLEN'(full >> XLEN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld   <= '0;
      res_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NM; i++) begin
        op_q[i]  <= OP_MUL;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      if (flush) begin
        vld <= '0;
      end else if (enable) begin
        vld <= {vld[LATENCY-2:0], in_valid};
      end
      if (enable) begin
        op_q[0]  <= op_in;
        a_q[0]   <= a_in_ext;
        b_q[0]   <= b_in_ext;
        tag_q[0] <= in_tag;
        acc_q[0] <= acc_n[0];
        for (int unsigned i = 1; i < NM; i++) begin
          op_q[i]  <= op_q[i-1];
          a_q[i]   <= a_q[i-1];
          b_q[i]   <= b_q[i-1];
          tag_q[i] <= tag_q[i-1];
          acc_q[i] <= acc_n[i];
        end
        tag_q[LATENCY-1] <= tag_q[LATENCY-2];
        res_q            <= res_n;
      end
    end
  end

  assign out_valid  = vld[LATENCY-1];
  assign out_result = res_q;
  assign out_tag    = tag_q[LATENCY-1];
  assign busy       = |vld;

endmodule
